// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - upstream bundle and issued-operand handshake bundle for alu_issue
// slave is the issue register's view; master is the upstream/ALU side.
interface alu_issue_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 3
);
  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             in_inst;
  logic [DATA_WIDTH-1:0]   in_pc;
  logic [DATA_WIDTH-1:0]   in_rs1;
  logic [DATA_WIDTH-1:0]   in_rs2;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   src1;
  logic [DATA_WIDTH-1:0]   src2;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic [4:0]              rd;
  logic                    wen;
  logic                    illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, src1, src2, alu_op, rd, wen, illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, src1, src2, alu_op, rd, wen, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - execute-stage issue register with decode and two-entry skid buffer
// Decode happens before storage so both entries hold ready-to-use ALU fields.
module alu_issue #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);

  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = ALU_OP_WIDTH'(3'b000);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = ALU_OP_WIDTH'(3'b101);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLT  = ALU_OP_WIDTH'(3'b010);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLTU = ALU_OP_WIDTH'(3'b011);
  localparam logic [ALU_OP_WIDTH-1:0] OP_XOR  = ALU_OP_WIDTH'(3'b100);
  localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = ALU_OP_WIDTH'(3'b110);
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = ALU_OP_WIDTH'(3'b111);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   src1;
    logic [DATA_WIDTH-1:0]   src2;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [4:0]              rd;
    logic                    wen;
    logic                    illegal;
  } entry_t;

  logic [6:0]              opcode;
  logic [2:0]              funct3;
  logic [6:0]              funct7;
  logic [DATA_WIDTH-1:0]   imm_i;
  logic [DATA_WIDTH-1:0]   imm_u;
  logic [ALU_OP_WIDTH-1:0] arith_op;
  logic                    arith_ok;
  logic                    legal;
  entry_t                  dec;

  assign opcode = bus.in_inst[6:0];
  assign funct3 = bus.in_inst[14:12];
  assign funct7 = bus.in_inst[31:25];
  assign imm_i  = DATA_WIDTH'($signed(bus.in_inst[31:20]));
  assign imm_u  = DATA_WIDTH'($signed({bus.in_inst[31:12], 12'b0}));

  // funct3 0x1/0x5 are shifts, which this ALU does not implement.
  always_comb begin
    arith_ok = 1'b1;
    arith_op = OP_ADD;
    case (funct3)
      3'b000:  arith_op = OP_ADD;
      3'b010:  arith_op = OP_SLT;
      3'b011:  arith_op = OP_SLTU;
      3'b100:  arith_op = OP_XOR;
      3'b110:  arith_op = OP_OR;
      3'b111:  arith_op = OP_AND;
      default: arith_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec        = '0;
    dec.alu_op = OP_ADD;
    dec.rd     = bus.in_inst[11:7];
    legal      = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec.src1 = bus.in_rs1;
        dec.src2 = bus.in_rs2;
        if (funct7 == 7'b0000000) begin
          legal      = arith_ok;
          dec.alu_op = arith_op;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          legal      = 1'b1;
          dec.alu_op = OP_SUB;
        end
      end
      7'b0010011: begin
        dec.src1   = bus.in_rs1;
        dec.src2   = imm_i;
        legal      = arith_ok;
        dec.alu_op = arith_op;
      end
      7'b0110111: begin
        dec.src2 = imm_u;
        legal    = 1'b1;
      end
      7'b0010111: begin
        dec.src1 = bus.in_pc;
        dec.src2 = imm_u;
        legal    = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.src1   = '0;
      dec.src2   = '0;
      dec.alu_op = OP_ADD;
    end
    dec.illegal = !legal;
    dec.wen     = legal && (dec.rd != 5'd0);
  end

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   accept, consume;

  assign accept  = bus.in_valid && !skid_valid_q;
  assign consume = main_valid_q && bus.out_ready;

  // in_ready depends only on skid occupancy, so it never sees out_ready combinationally.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (consume && skid_valid_q) begin
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      if (!main_valid_q || consume) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end else if (consume) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready  = !skid_valid_q;
  assign bus.out_valid = main_valid_q;
  assign bus.src1      = main_q.src1;
  assign bus.src2      = main_q.src2;
  assign bus.alu_op    = main_q.alu_op;
  assign bus.rd        = main_q.rd;
  assign bus.wen       = main_q.wen;
  assign bus.illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed and random-handshake bench for alu_issue
// Expected results come from a hand-decoded instruction table.
module tb_alu_issue;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_if #(.DATA_WIDTH(32), .ALU_OP_WIDTH(3)) bus ();

  alu_issue #(.DATA_WIDTH(32), .ALU_OP_WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } res_t;

  // s1: 0=zero 1=rs1 2=pc ; s2: 0=zero 1=rs2 2=imm
  typedef struct {
    logic [31:0] inst;
    int          s1;
    int          s2;
    logic [31:0] imm;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl[NV];
  int   total = 0;
  int   bad   = 0;

  task automatic init_table();
    tbl[0]  = '{32'h002081B3, 1, 1, 32'h0,        3'b000, 5'd3,  1'b1, 1'b0}; // add x3,x1,x2
    tbl[1]  = '{32'h407302B3, 1, 1, 32'h0,        3'b101, 5'd5,  1'b1, 1'b0}; // sub x5,x6,x7
    tbl[2]  = '{32'hFFF00093, 1, 2, 32'hFFFFFFFF, 3'b000, 5'd1,  1'b1, 1'b0}; // addi x1,x0,-1
    tbl[3]  = '{32'h12345217, 2, 2, 32'h12345000, 3'b000, 5'd4,  1'b1, 1'b0}; // auipc x4
    tbl[4]  = '{32'h00109093, 0, 0, 32'h0,        3'b000, 5'd1,  1'b0, 1'b1}; // slli
    tbl[5]  = '{32'h00208033, 1, 1, 32'h0,        3'b000, 5'd0,  1'b0, 1'b0}; // add x0
    tbl[6]  = '{32'hABCDE537, 0, 2, 32'hABCDE000, 3'b000, 5'd10, 1'b1, 1'b0}; // lui x10
    tbl[7]  = '{32'h7FF44393, 1, 2, 32'h000007FF, 3'b100, 5'd7,  1'b1, 1'b0}; // xori x7,x8,0x7ff
    tbl[8]  = '{32'h0020B4B3, 1, 1, 32'h0,        3'b011, 5'd9,  1'b1, 1'b0}; // sltu x9
    tbl[9]  = '{32'h0020F5B3, 1, 1, 32'h0,        3'b111, 5'd11, 1'b1, 1'b0}; // and x11
    tbl[10] = '{32'h0000A603, 0, 0, 32'h0,        3'b000, 5'd12, 1'b0, 1'b1}; // lw
    tbl[11] = '{32'h4020F5B3, 0, 0, 32'h0,        3'b000, 5'd11, 1'b0, 1'b1}; // bad funct7
    tbl[12] = '{32'h8000A693, 1, 2, 32'hFFFFF800, 3'b010, 5'd13, 1'b1, 1'b0}; // slti -2048
    tbl[13] = '{32'h0020E733, 1, 1, 32'h0,        3'b110, 5'd14, 1'b1, 1'b0}; // or x14
  endtask

  function automatic res_t expect_res(int k, logic [31:0] rs1, logic [31:0] rs2, logic [31:0] pc);
    res_t r;
    r.src1 = (tbl[k].s1 == 1) ? rs1 : (tbl[k].s1 == 2) ? pc : 32'h0;
    r.src2 = (tbl[k].s2 == 1) ? rs2 : (tbl[k].s2 == 2) ? tbl[k].imm : 32'h0;
    r.op   = tbl[k].op;
    r.rd   = tbl[k].rd;
    r.wen  = tbl[k].wen;
    r.ill  = tbl[k].ill;
    return r;
  endfunction

  function automatic res_t observed();
    return {bus.src1, bus.src2, bus.alu_op, bus.rd, bus.wen, bus.illegal};
  endfunction

  task automatic drive_in(int k, logic [31:0] rs1, logic [31:0] rs2, logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_inst  = tbl[k].inst;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_pc    = pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_inst = '0; bus.in_pc = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    repeat (2) @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b exp=0", bus.out_valid); end
    total++; if (observed() !== res_t'(0)) begin bad++; $display("FAIL reset outputs got=%h exp=0", observed()); end
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    logic [31:0] rs1, rs2;
    bus.out_ready = 1'b1;
    for (int k = 0; k < NV; k++) begin
      rs1 = (k == 0) ? 32'd5 : 32'h1000_0001 * k;
      rs2 = (k == 0) ? 32'd7 : 32'h0200_0300 * k + 32'h9;
      @(negedge clk);
      drive_in(k, rs1, rs2, 32'h8000_0000);
      @(negedge clk);
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL decode[%0d] out_valid got=%b exp=1", k, bus.out_valid); end
      total++; if (observed() !== expect_res(k, rs1, rs2, 32'h8000_0000)) begin
        bad++; $display("FAIL decode[%0d] fields got=%h exp=%h", k, observed(), expect_res(k, rs1, rs2, 32'h8000_0000));
      end
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL decode[%0d] drain out_valid got=%b exp=0", k, bus.out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    res_t prev;
    bus.out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        total++; if (bus.out_valid !== 1'b1 || observed() !== prev) begin
          bad++; $display("FAIL b2b[%0d] got=%b/%h exp=1/%h", k - 1, bus.out_valid, observed(), prev);
        end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b[%0d] in_ready got=%b exp=1", k, bus.in_ready); end
      end
      if (k < 8) begin
        drive_in(k + 6, 32'hA0 + k, 32'hB0 + k, 32'h100 + k);
        prev = expect_res(k + 6, 32'hA0 + k, 32'hB0 + k, 32'h100 + k);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b tail out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic exp_rdy[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic exp_ov[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int   exp_idx[8] = '{0, 0, 0, 0, 1, 2, 3, 0};
    int   nxt = 0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++; if (bus.in_ready !== exp_rdy[c]) begin bad++; $display("FAIL bp c%0d in_ready got=%b exp=%b", c, bus.in_ready, exp_rdy[c]); end
      total++; if (bus.out_valid !== exp_ov[c]) begin bad++; $display("FAIL bp c%0d out_valid got=%b exp=%b", c, bus.out_valid, exp_ov[c]); end
      if (exp_ov[c]) begin
        total++; if (observed() !== expect_res(exp_idx[c], 32'h100 + exp_idx[c], 32'h200 + exp_idx[c], 32'h8000_0000)) begin
          bad++; $display("FAIL bp c%0d data got=%h exp=%h", c, observed(),
                          expect_res(exp_idx[c], 32'h100 + exp_idx[c], 32'h200 + exp_idx[c], 32'h8000_0000));
        end
      end
      bus.out_ready = (c >= 3);
      if (nxt < 4) drive_in(nxt, 32'h100 + nxt, 32'h200 + nxt, 32'h8000_0000);
      else bus.in_valid = 1'b0;
      if (bus.in_valid && bus.in_ready) nxt++;
    end
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b0;
    @(negedge clk); drive_in(0, 32'h11, 32'h22, 32'h0);
    @(negedge clk); drive_in(1, 32'h33, 32'h44, 32'h0);
    @(negedge clk); bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL midrst full in_ready/out_valid got=%b/%b exp=0/1", bus.in_ready, bus.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst in_ready got=%b exp=1", bus.in_ready); end
    total++; if (observed() !== res_t'(0)) begin bad++; $display("FAIL midrst outputs got=%h exp=0", observed()); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst stale out_valid got=%b exp=0", bus.out_valid); end
    drive_in(6, 32'h55, 32'h66, 32'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || observed() !== expect_res(6, 32'h55, 32'h66, 32'h0)) begin
      bad++; $display("FAIL midrst new got=%b/%h exp=1/%h", bus.out_valid, observed(), expect_res(6, 32'h55, 32'h66, 32'h0));
    end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst after out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    res_t        q[$];
    res_t        cur_exp, prev_obs, e;
    int          sent = 0, got = 0, cyc = 0, k;
    logic        have_cur = 1'b0, stalled_prev = 1'b0;
    logic [31:0] rs1, rs2, pc;
    while (got < N && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (stalled_prev) begin
        total++; if (bus.out_valid !== 1'b1 || observed() !== prev_obs) begin
          bad++; $display("FAIL rand stall cyc=%0d got=%b/%h exp=1/%h", cyc, bus.out_valid, observed(), prev_obs);
        end
      end
      if (!have_cur && sent < N) begin
        k = $urandom_range(0, NV - 1);
        rs1 = $urandom; rs2 = $urandom; pc = $urandom;
        drive_in(k, rs1, rs2, pc);
        cur_exp  = expect_res(k, rs1, rs2, pc);
        have_cur = 1'b1;
      end
      bus.in_valid  = have_cur && ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand extra bundle cyc=%0d got=%h exp=none", cyc, observed());
        end else begin
          e = q.pop_front();
          got++;
          if (observed() !== e) begin bad++; $display("FAIL rand order #%0d got=%h exp=%h", got, observed(), e); end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(cur_exp);
        sent++;
        have_cur = 1'b0;
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      prev_obs     = observed();
    end
    total++; if (got != N) begin bad++; $display("FAIL rand count got=%0d exp=%0d", got, N); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rand drain out_valid got=%b exp=0", bus.out_valid); end
  endtask

  initial begin
    init_table();
    test_reset();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage issue register that feeds the ALU. It accepts one decoded-register-read bundle per cycle (instruction, PC, rs1/rs2 data) over a valid/ready handshake. It decodes the bundle into `src1`/`src2`/`alu_op` using the team ALU op encoding and presents the result, registered, to the ALU and writeback over a second valid/ready handshake. A two-entry skid buffer gives full throughput with a registered `in_ready`.

## Interface
- `DATA_WIDTH`, 32, operand/PC width (RV32)
- `ALU_OP_WIDTH`, 3, width of `alu_op`
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream bundle valid
- `in_ready`  out  1  block can accept a bundle
- `in_inst`  in  32  instruction word
- `in_pc`  in  DATA_WIDTH  instruction PC
- `in_rs1`  in  DATA_WIDTH  rs1 register value
- `in_rs2`  in  DATA_WIDTH  rs2 register value
- `out_valid`  out  1  issued bundle valid
- `out_ready`  in  1  ALU/writeback consumes bundle
- `src1`  out  DATA_WIDTH  ALU operand 1
- `src2`  out  DATA_WIDTH  ALU operand 2
- `alu_op`  out  ALU_OP_WIDTH  ALU operation code
- `rd`  out  5  destination register index
- `wen`  out  1  writeback enable
- `illegal`  out  1  instruction not executable by the ALU

## Operation
- ALU op codes: ADD=000, SUB=101, SLT=010, SLTU=011, XOR=100, OR=110, AND=111.
- OP (opcode 0110011):
  - src1=rs1, src2=rs2.
  - funct7=0000000: funct3 000/010/011/100/110/111 map to ADD/SLT/SLTU/XOR/OR/AND.
  - funct7=0100000 with funct3=000: SUB.
- OP-IMM (0010011):
  - src1=rs1, src2=sign-extended imm[31:20].
  - funct3 000/010/011/100/110/111 map to ADD/SLT/SLTU/XOR/OR/AND.
- LUI (0110111): src1=0, src2={inst[31:12],12'b0}, ADD.
- AUIPC (0010111): src1=pc, src2={inst[31:12],12'b0}, ADD.
- Illegal: shifts (funct3 001/101), any other funct7 on OP, and all other opcodes.
  - Outputs: illegal=1, wen=0, src1=src2=0, alu_op=ADD.
  - The bundle is still issued and handshaken normally.
- `rd` = inst[11:7] always. `wen` = legal && rd≠0.
- Decode is combinational on the input side. Both buffer entries store already-decoded fields.
- Buffer entries:
  - main: drives the outputs; `out_valid` = main_valid.
  - skid: `in_ready` = !skid_valid.
- Accept is `in_valid && in_ready`. Consume is `out_valid && out_ready`. Per cycle:
  - accept, main empty or consumed, skid empty: load into main.
  - accept, main full and not consumed: load into skid.
  - consume with skid full: skid moves to main, skid empties. No accept is possible in this case, since in_ready=0.
  - consume with skid empty and no accept: main empties.
- Order is strictly preserved. No bundle is ever dropped or duplicated.

## Timing
- Latency: a bundle accepted at edge N appears on the outputs after edge N, so it is consumable in cycle N+1 when the buffer is empty.
- Throughput: 1 bundle per cycle while `out_ready`=1.
- `in_ready` is a pure register output and has no combinational path from `out_ready`.
- Outputs are stable while `out_valid`=1 and `out_ready`=0.
- `out_valid` never drops without a consume.
- Reset (`rst_n`=0, asynchronous) state and outputs:
  - main_valid=0, skid_valid=0.
  - out_valid=0, in_ready=1.
  - src1=src2=0, alu_op=000, rd=0, wen=0, illegal=0.
- Reset mid-transfer discards both entries. The first accept after `rst_n` rises is on the first rising edge with `in_valid`=1.

## Test plan
- Single `add x3,x1,x2` (0x002081B3) with rs1=5, rs2=7, out_ready=1.
  - Next cycle: out_valid=1, src1=5, src2=7, alu_op=000, rd=3, wen=1, illegal=0.
- `sub x5,x6,x7` (0x407302B3) -> alu_op=101.
- `addi x1,x0,-1` (0xFFF00093) -> src2=0xFFFFFFFF, alu_op=000.
- `auipc x4,0x12345` at pc=0x80000000 (0x12345217) -> src1=0x80000000, src2=0x12345000.
- `slli` (0x00109093) -> illegal=1, wen=0, src1=src2=0.
- `add x0,x1,x2` (0x00208033) -> wen=0, illegal=0.
- Backpressure: stream of 4 bundles with out_ready=0 for 3 cycles.
  - in_ready falls after the 2nd accept; outputs hold bundle 1.
  - After out_ready=1, all 4 bundles emerge in order with no gaps, and in_ready returns to 1.
- Random valid/ready toggling over 10k bundles.
  - Scoreboard: order preserved, no loss or duplication.
  - Outputs stable while stalled.
  - out_valid never drops without a consume.
- Assert rst_n low with both entries full.
  - Immediately: out_valid=0, in_ready=1.
  - Post-reset: only new bundles are issued.
